// File: rtl/uart_rx_ctrl.sv
// Oversampled UART receiver: validates the start bit at half-bit, samples data mid-bit,
// checks optional parity and one or two stop bits, and delivers each frame with a valid strobe.
module uart_rx_ctrl #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int TCW        = $clog2(OVERSAMPLE)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 baud_tick,
   input  logic                 rx,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 two_stop,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int             BCW       = $clog2(DATA_BITS);
   localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
   localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               state_reg;
   logic [TCW-1:0]       tick_cnt_reg;
   logic [BCW-1:0]       bit_cnt_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 armed_reg;
   logic                 par_en_reg;
   logic                 par_odd_reg;
   logic                 two_stop_reg;
   logic                 stop_cnt_reg;
   logic                 perr_reg;
   logic                 ferr_reg;

   logic half_tick;
   logic full_tick;

   assign half_tick = baud_tick && (tick_cnt_reg == HALF_LAST);
   assign full_tick = baud_tick && (tick_cnt_reg == FULL_LAST);
   assign busy      = (state_reg != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         tick_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         armed_reg    <= 1'b0;
         par_en_reg   <= 1'b0;
         par_odd_reg  <= 1'b0;
         two_stop_reg <= 1'b0;
         stop_cnt_reg <= 1'b0;
         perr_reg     <= 1'b0;
         ferr_reg     <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               tick_cnt_reg <= '0;
               // A low line only counts as a start once it has been seen idle-high,
               // so a break held after a frame cannot retrigger the receiver.
               if (rx) begin
                  armed_reg <= 1'b1;
               end else if (armed_reg) begin
                  armed_reg    <= 1'b0;
                  state_reg    <= START;
                  par_en_reg   <= parity_en;
                  par_odd_reg  <= parity_odd;
                  two_stop_reg <= two_stop;
                  perr_reg     <= 1'b0;
                  ferr_reg     <= 1'b0;
               end
            end

            START: begin
               if (half_tick) begin
                  tick_cnt_reg <= '0;
                  bit_cnt_reg  <= '0;
                  state_reg    <= rx ? IDLE : DATA;
               end else if (baud_tick) begin
                  tick_cnt_reg <= tick_cnt_reg + TCW'(1);
               end
            end

            DATA: begin
               if (full_tick) begin
                  tick_cnt_reg <= '0;
                  shift_reg    <= {rx, shift_reg[DATA_BITS-1:1]};
                  if (bit_cnt_reg == BIT_LAST) begin
                     stop_cnt_reg <= 1'b0;
                     state_reg    <= par_en_reg ? PARITY : STOP;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + BCW'(1);
                  end
               end else if (baud_tick) begin
                  tick_cnt_reg <= tick_cnt_reg + TCW'(1);
               end
            end

            PARITY: begin
               if (full_tick) begin
                  tick_cnt_reg <= '0;
                  perr_reg     <= (^shift_reg) ^ rx ^ par_odd_reg;
                  stop_cnt_reg <= 1'b0;
                  state_reg    <= STOP;
               end else if (baud_tick) begin
                  tick_cnt_reg <= tick_cnt_reg + TCW'(1);
               end
            end

            STOP: begin
               if (full_tick) begin
                  tick_cnt_reg <= '0;
                  // Completing mid-stop-bit leaves half a bit to re-arm for a back-to-back frame.
                  if (two_stop_reg && !stop_cnt_reg) begin
                     stop_cnt_reg <= 1'b1;
                     ferr_reg     <= ferr_reg | ~rx;
                  end else begin
                     rx_valid   <= 1'b1;
                     rx_data    <= shift_reg;
                     parity_err <= perr_reg;
                     frame_err  <= ferr_reg | ~rx;
                     state_reg  <= IDLE;
                  end
               end else if (baud_tick) begin
                  tick_cnt_reg <= tick_cnt_reg + TCW'(1);
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
